// File: rtl/memsum_loader_if.sv
// -----------------------------------------------------------------------------
// memsum_loader_if
//   Bundles the loader's control inputs, the operand valid/ready stream, the
//   memory write port and the status outputs into one interface.
//   Ports (all carried as interface signals):
//     iStart, iAbort           host control into the loader
//     iInValid, iInData        operand stream from the host
//     oInReady                 loader accepts iInData this cycle
//     oWrEn, oWrAddr, oWrData  registered memory write port
//     oBusy, oDone, oLoadSum   load status towards host / sum controller
//   Modports:
//     slave  - the loader itself
//     master - the host side that drives control and stream inputs
// -----------------------------------------------------------------------------
interface memsum_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              iStart;
    logic              iAbort;
    logic              iInValid;
    logic [DATA_W-1:0] iInData;
    logic              oInReady;
    logic              oWrEn;
    logic [ADDR_W-1:0] oWrAddr;
    logic [DATA_W-1:0] oWrData;
    logic              oBusy;
    logic              oDone;
    logic [DATA_W-1:0] oLoadSum;

    modport slave (
        input  iStart, iAbort, iInValid, iInData,
        output oInReady, oWrEn, oWrAddr, oWrData, oBusy, oDone, oLoadSum
    );

    modport master (
        output iStart, iAbort, iInValid, iInData,
        input  oInReady, oWrEn, oWrAddr, oWrData, oBusy, oDone, oLoadSum
    );
endinterface

// File: rtl/memsum_loader.sv
// -----------------------------------------------------------------------------
// memsum_loader
//   Host-side writer for the sum engine's register memory. Accepts DEPTH
//   operand bytes over a valid/ready stream and writes them to addresses
//   0..DEPTH-1 with one cycle of latency, keeping a running mod-2**DATA_W sum
//   of the accepted bytes. oBusy holds the sum controller off the write port
//   while loading; oDone pulses in the cycle the last operand is written.
//   Ports:
//     iClk  - clock, single domain
//     iRst  - synchronous active-high reset
//     bus   - memsum_loader_if.slave: control, operand stream, memory write
//             port and status (see memsum_loader_if for the signal list)
//   Parameters:
//     DATA_W - operand / memory word width
//     ADDR_W - memory address width
//     DEPTH  - operands per load, 1..2**ADDR_W
// -----------------------------------------------------------------------------
module memsum_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    memsum_loader_if.slave     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [1:0]        stateReg,  stateNext;
    logic [ADDR_W-1:0] ptrReg,    ptrNext;
    logic [DATA_W-1:0] sumReg,    sumNext;
    logic              wrEnReg;
    logic [ADDR_W-1:0] wrAddrReg;
    logic [DATA_W-1:0] wrDataReg;

    logic inReady;
    logic accept;

    // Abort blocks acceptance in the same cycle so the byte on the bus is
    // left with the source rather than half-loaded.
    assign inReady = (stateReg == LOAD) && !bus.iAbort;
    assign accept  = bus.iInValid && inReady;

    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        sumNext   = sumReg;
        case (stateReg)
            IDLE: begin
                // Start wins over a simultaneous abort: abort only acts in LOAD.
                if (bus.iStart) begin
                    stateNext = LOAD;
                    ptrNext   = '0;
                    sumNext   = '0;
                end
            end
            LOAD: begin
                if (bus.iAbort) begin
                    stateNext = IDLE;
                end else if (accept) begin
                    ptrNext = ptrReg + 1'b1;
                    sumNext = sumReg + bus.iInData;
                    if (ptrReg == LAST_PTR) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg  <= IDLE;
            ptrReg    <= '0;
            sumReg    <= '0;
            wrEnReg   <= 1'b0;
            wrAddrReg <= '0;
            wrDataReg <= '0;
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
            sumReg   <= sumNext;
            wrEnReg  <= accept;
            // Address/data only move on a real write so the bus stays quiet
            // between operands.
            if (accept) begin
                wrAddrReg <= ptrReg;
                wrDataReg <= bus.iInData;
            end
        end
    end

    // The DONE cycle lines up with the write of the last operand because the
    // write port is one register stage behind the accept.
    assign bus.oInReady = inReady;
    assign bus.oWrEn    = wrEnReg;
    assign bus.oWrAddr  = wrAddrReg;
    assign bus.oWrData  = wrDataReg;
    assign bus.oBusy    = (stateReg == LOAD);
    assign bus.oDone    = (stateReg == DONE);
    assign bus.oLoadSum = sumReg;
endmodule

// File: tb/tb_memsum_loader.sv
// -----------------------------------------------------------------------------
// tb_memsum_loader
//   Directed bench for memsum_loader (DATA_W=8, ADDR_W=2, DEPTH=4). A negedge
//   monitor logs accepts, writes and done pulses and keeps a copy of the
//   register memory; each test then compares the log against hand-computed
//   expected values through checkVal.
// -----------------------------------------------------------------------------
module tb_memsum_loader;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memsum_loader_if #(.DATA_W(8), .ADDR_W(2)) busIf ();

    memsum_loader #(.DATA_W(8), .ADDR_W(2), .DEPTH(4)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (busIf)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    int          cyc = 0;
    int          accCycQ[$];
    int          wrCycQ[$];
    int          wrAddrQ[$];
    logic [7:0]  wrDataQ[$];
    int          doneCnt;
    logic        doneWr;
    logic [7:0]  doneSum;
    logic [7:0]  mem[4];

    logic [7:0] vecT2[4] = '{8'h05, 8'h0A, 8'h14, 8'h1E};
    logic [7:0] vecT4[4] = '{8'hFF, 8'hFF, 8'h02, 8'h01};
    logic [7:0] vecT5[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] vecT6[4] = '{8'h01, 8'h02, 8'h03, 8'h04};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // One line per memory write; accepts and done pulses are logged quietly.
    always @(negedge clk) begin
        if (busIf.iInValid && busIf.oInReady && !rst) begin
            accCycQ.push_back(cyc);
        end
        if (busIf.oWrEn) begin
            wrCycQ.push_back(cyc);
            wrAddrQ.push_back(int'(busIf.oWrAddr));
            wrDataQ.push_back(busIf.oWrData);
            mem[busIf.oWrAddr] = busIf.oWrData;
            $display("[TB] cycle %0d write addr=%0d data=0x%02h done=%0b sum=0x%02h",
                     cyc, busIf.oWrAddr, busIf.oWrData, busIf.oDone, busIf.oLoadSum);
        end
        if (busIf.oDone) begin
            doneCnt++;
            doneWr  = busIf.oWrEn;
            doneSum = busIf.oLoadSum;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        accCycQ.delete();
        wrCycQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCnt = 0;
        doneWr  = 1'b0;
        doneSum = 8'h00;
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_inReady"}, 32'(busIf.oInReady), 32'd0);
        checkVal({tag, "_wrEn"},    32'(busIf.oWrEn),    32'd0);
        checkVal({tag, "_wrAddr"},  32'(busIf.oWrAddr),  32'd0);
        checkVal({tag, "_wrData"},  32'(busIf.oWrData),  32'd0);
        checkVal({tag, "_busy"},    32'(busIf.oBusy),    32'd0);
        checkVal({tag, "_done"},    32'(busIf.oDone),    32'd0);
        checkVal({tag, "_sum"},     32'(busIf.oLoadSum), 32'd0);
    endtask

    task automatic startLoad(input string tag, input bit withAbort);
        busIf.iStart = 1'b1;
        busIf.iAbort = withAbort;
        tick();
        busIf.iStart = 1'b0;
        busIf.iAbort = 1'b0;
        #1;
        checkVal({tag, "_startBusy"}, 32'(busIf.oBusy),    32'd1);
        checkVal({tag, "_startSum0"}, 32'(busIf.oLoadSum), 32'd0);
    endtask

    // Presents b[0..n-1]; gap idle cycles between bytes (busy checked in each).
    // Returns in the cycle after the last accept.
    task automatic sendBytes(input string tag, input logic [7:0] b[4], input int n,
                             input int gap, input bit startMid);
        for (int i = 0; i < n; i++) begin
            busIf.iInValid = 1'b1;
            busIf.iInData  = b[i];
            if (startMid && i == 1) busIf.iStart = 1'b1;
            #1;
            for (int g = 0; g < 20 && !busIf.oInReady; g++) begin
                tick();
                #1;
            end
            checkVal($sformatf("%s_ready%0d", tag, i), 32'(busIf.oInReady), 32'd1);
            tick();
            busIf.iInValid = 1'b0;
            busIf.iStart   = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    #1;
                    checkVal($sformatf("%s_gapBusy%0d_%0d", tag, i, g), 32'(busIf.oBusy), 32'd1);
                    tick();
                end
            end
        end
    endtask

    task automatic checkWrites(input string tag, input logic [7:0] b[4], input int n);
        checkVal({tag, "_wrCount"}, 32'(wrAddrQ.size()), 32'(n));
        for (int i = 0; i < n && i < wrAddrQ.size() && i < accCycQ.size(); i++) begin
            checkVal($sformatf("%s_addr%0d", tag, i), 32'(wrAddrQ[i]), 32'(i));
            checkVal($sformatf("%s_data%0d", tag, i), 32'(wrDataQ[i]), 32'(b[i]));
            checkVal($sformatf("%s_lat%0d", tag, i), 32'(wrCycQ[i] - accCycQ[i]), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        clearLog();
        rst            = 1'b1;
        busIf.iStart   = 1'b0;
        busIf.iAbort   = 1'b0;
        busIf.iInValid = 1'b0;
        busIf.iInData  = 8'h00;
        repeat (2) tick();
        checkReset("por");
        rst = 1'b0;
        tick();

        // T1: reset with a third byte on the bus after two accepts
        clearLog();
        startLoad("t1", 1'b0);
        sendBytes("t1", vecT2, 2, 0, 1'b0);
        busIf.iInValid = 1'b1;
        busIf.iInData  = 8'h14;
        rst            = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkReset("t1");
        busIf.iInValid = 1'b0;
        repeat (4) tick();
        checkVal("t1_wrCount", 32'(wrAddrQ.size()), 32'd2);
        checkVal("t1_doneCnt", 32'(doneCnt), 32'd0);

        // T2: back-to-back load
        clearLog();
        startLoad("t2", 1'b0);
        sendBytes("t2", vecT2, 4, 0, 1'b0);
        #1;
        checkVal("t2_doneNow", 32'(busIf.oDone), 32'd1);
        repeat (3) tick();
        checkWrites("t2", vecT2, 4);
        checkVal("t2_doneCnt", 32'(doneCnt), 32'd1);
        checkVal("t2_doneWr",  32'(doneWr),  32'd1);
        checkVal("t2_doneSum", 32'(doneSum), 32'h41);
        checkVal("t2_sumHeld", 32'(busIf.oLoadSum), 32'h41);
        checkVal("t2_idleBusy", 32'(busIf.oBusy), 32'd0);

        // T3: two idle cycles between bytes
        clearLog();
        startLoad("t3", 1'b0);
        sendBytes("t3", vecT2, 4, 2, 1'b0);
        repeat (3) tick();
        checkWrites("t3", vecT2, 4);
        checkVal("t3_doneCnt", 32'(doneCnt), 32'd1);
        checkVal("t3_doneSum", 32'(doneSum), 32'h41);

        // T4: sum wraps
        clearLog();
        startLoad("t4", 1'b0);
        sendBytes("t4", vecT4, 4, 0, 1'b0);
        repeat (3) tick();
        checkWrites("t4", vecT4, 4);
        checkVal("t4_doneCnt", 32'(doneCnt), 32'd1);
        checkVal("t4_doneSum", 32'(doneSum), 32'h01);

        // T5: abort while presenting the third byte, then reload
        clearLog();
        startLoad("t5", 1'b0);
        sendBytes("t5", vecT5, 2, 0, 1'b0);
        busIf.iInValid = 1'b1;
        busIf.iInData  = vecT5[2];
        busIf.iAbort   = 1'b1;
        #1;
        checkVal("t5_abortReady", 32'(busIf.oInReady), 32'd0);
        tick();
        busIf.iAbort   = 1'b0;
        busIf.iInValid = 1'b0;
        #1;
        checkVal("t5_abortBusy", 32'(busIf.oBusy), 32'd0);
        repeat (3) tick();
        checkWrites("t5", vecT5, 2);
        checkVal("t5_doneCnt", 32'(doneCnt), 32'd0);
        checkVal("t5_mem2", 32'(mem[2]), 32'h02);
        checkVal("t5_mem3", 32'(mem[3]), 32'h01);
        clearLog();
        startLoad("t5r", 1'b0);
        sendBytes("t5r", vecT5, 4, 0, 1'b0);
        repeat (3) tick();
        checkWrites("t5r", vecT5, 4);
        checkVal("t5r_doneCnt", 32'(doneCnt), 32'd1);
        checkVal("t5r_doneSum", 32'(doneSum), 32'hAA);

        // T6: start+abort in IDLE (start wins), start ignored in LOAD and DONE
        clearLog();
        startLoad("t6", 1'b1);
        sendBytes("t6", vecT6, 4, 0, 1'b1);
        busIf.iStart = 1'b1;
        #1;
        checkVal("t6_doneNow", 32'(busIf.oDone), 32'd1);
        tick();
        busIf.iStart = 1'b0;
        #1;
        checkVal("t6_afterDoneBusy", 32'(busIf.oBusy), 32'd0);
        repeat (3) tick();
        checkWrites("t6", vecT6, 4);
        checkVal("t6_doneCnt", 32'(doneCnt), 32'd1);
        checkVal("t6_doneSum", 32'(doneSum), 32'h0A);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
